// File: rtl/fifo_uart_transmitter.sv
// FIFO drain-side UART transmitter: pops one word per frame through the FIFO
// read handshake and shifts it out as start, data LSB first, optional even parity, stop.
module fifo_uart_transmitter #(
    parameter int DATA_WIDTH     = 8,
    parameter int CLOCKS_PER_BIT = 16,
    parameter int STOP_BITS      = 1,
    parameter int PARITY_ENABLE  = 0
) (
    input  logic                  Read_Clock,
    input  logic                  Read_Reset_Enable,
    input  logic                  Tx_Enable,
    input  logic                  FIFO_Empty,
    input  logic [DATA_WIDTH-1:0] FIFO_Data,
    output logic                  Read_Enable,
    output logic                  Serial_Out,
    output logic                  Busy,
    output logic                  Frame_Done
);

    localparam int DIV_W = $clog2(CLOCKS_PER_BIT);
    localparam int BIT_W = ($clog2(DATA_WIDTH) > 0) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLOCKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    parity_q, parity_d;
    logic                    read_enable_q, read_enable_d;
    logic                    serial_q, serial_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;
    logic                    bit_end;
    logic                    can_pop;

    // NOTE: state and output flops use non-blocking assignments and an async
    // reset, so a mid-frame reset drops the line back to idle without a clock.
    always_ff @(posedge Read_Clock or posedge Read_Reset_Enable) begin
        if (Read_Reset_Enable) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            read_enable_q <= 1'b0;
            serial_q      <= 1'b1;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            read_enable_q <= read_enable_d;
            serial_q      <= serial_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // NOTE: every signal gets its hold value first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        div_d    = '0;
        bit_end  = (div_q == DIV_LAST);
        can_pop  = Tx_Enable && !FIFO_Empty;

        unique case (state_q)
            S_IDLE: begin
                if (can_pop) state_d = S_POP;
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d  = FIFO_Data;
                parity_d = ^FIFO_Data;
                bit_d    = '0;
                state_d  = S_START;
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_ENABLE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = can_pop ? S_POP : S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Divider restarts on every state entry and wraps at each bit boundary.
        if (state_d inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
            if (state_d != state_q || bit_end) div_d = '0;
            else                               div_d = div_q + 1'b1;
        end

        // Outputs are decoded from the next-cycle values so they are registered.
        read_enable_d = (state_d == S_POP);
        busy_d        = (state_d != S_IDLE);
        frame_done_d  = (state_d == S_STOP) && (div_d == DIV_LAST) && (bit_d == STOP_LAST);
        case (state_d)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = shift_d[0];
            S_PARITY: serial_d = parity_d;
            default:  serial_d = 1'b1;
        endcase
    end

    assign Read_Enable = read_enable_q;
    assign Serial_Out  = serial_q;
    assign Busy        = busy_q;
    assign Frame_Done  = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_transmitter.sv
// Bench for fifo_uart_transmitter: two instances (plain 8N1 and 8E2) fed from one
// word list, checked each cycle against a frame-template model plus literal expectations.
module tb_fifo_uart_transmitter;

    localparam int CPB    = 4;
    localparam int TR     = 8192;
    localparam int RE_B   = 3;
    localparam int SER_B  = 2;
    localparam int BUSY_B = 1;
    localparam int DONE_B = 0;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       tx_en = 1'b0;
    logic [1:0] fifo_empty = 2'b11;
    logic [7:0] fifo_data [2] = '{8'h00, 8'h00};
    logic [1:0] re, ser, busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0] words [$];
    logic [7:0] sent  [$];
    logic [7:0] dec_q [$];
    int         rd_ptr [2];
    int         pops   [2];
    bit         m_act  [2];
    int         m_idx  [2];
    logic [7:0] m_word [2];
    logic [3:0] trace  [2][TR];

    always #5 clk = ~clk;

    fifo_uart_transmitter #(
        .DATA_WIDTH(8), .CLOCKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ENABLE(0)
    ) dut_a (
        .Read_Clock(clk), .Read_Reset_Enable(rst), .Tx_Enable(tx_en),
        .FIFO_Empty(fifo_empty[0]), .FIFO_Data(fifo_data[0]),
        .Read_Enable(re[0]), .Serial_Out(ser[0]), .Busy(busy[0]), .Frame_Done(done[0])
    );

    fifo_uart_transmitter #(
        .DATA_WIDTH(8), .CLOCKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ENABLE(1)
    ) dut_b (
        .Read_Clock(clk), .Read_Reset_Enable(rst), .Tx_Enable(tx_en),
        .FIFO_Empty(fifo_empty[1]), .FIFO_Data(fifo_data[1]),
        .Read_Enable(re[1]), .Serial_Out(ser[1]), .Busy(busy[1]), .Frame_Done(done[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Serial bits per frame and total busy cycles (POP + LOAD + bits) per instance.
    function automatic int nbits(input int u);
        return (u == 1) ? 12 : 10;
    endfunction

    function automatic int frame_len(input int u);
        return 2 + CPB * nbits(u);
    endfunction

    // Expected {re, ser, busy, done} for cycle i of a frame carrying word w.
    function automatic logic [3:0] model_tuple(input int u, input logic [7:0] w, input int i);
        int   b;
        logic s;
        if (i == 0) return 4'b1110;
        if (i == 1) return 4'b0110;
        b = (i - 2) / CPB;
        if (b == 0)                 s = 1'b0;
        else if (b <= 8)            s = w[b-1];
        else if (u == 1 && b == 9)  s = ^w;
        else                        s = 1'b1;
        return {1'b0, s, 1'b1, (i == frame_len(u) - 1)};
    endfunction

    function automatic logic [3:0] tr(input int u, input int i);
        if (i < 0 || i >= TR) return 4'b0000;
        return trace[u][i];
    endfunction

    function automatic int first_idx(input int u, input int from, input int to, input int pos, input logic val);
        logic [3:0] t;
        for (int i = from; i <= to; i++) begin
            t = tr(u, i);
            if (t[pos] == val) return i;
        end
        return -1;
    endfunction

    function automatic int count_bit(input int u, input int from, input int to, input int pos);
        int         n = 0;
        logic [3:0] t;
        for (int i = from; i <= to; i++) begin
            t = tr(u, i);
            if (t[pos]) n++;
        end
        return n;
    endfunction

    task automatic update_flags();
        for (int u = 0; u < 2; u++) fifo_empty[u] = (rd_ptr[u] >= words.size());
    endtask

    task automatic push(input logic [7:0] w);
        words.push_back(w);
        update_flags();
    endtask

    // Frame-level model: at each edge advance the running frame, then start a new
    // one if the transmitter is free, enabled and its FIFO holds a word.
    task automatic model_edge();
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                m_act[u] = 1'b0;
                continue;
            end
            if (m_act[u]) begin
                m_idx[u]++;
                if (m_idx[u] == frame_len(u)) m_act[u] = 1'b0;
            end
            if (!m_act[u] && tx_en && rd_ptr[u] < words.size()) begin
                m_act[u]  = 1'b1;
                m_idx[u]  = 0;
                m_word[u] = words[rd_ptr[u]];
            end
        end
    endtask

    task automatic fifo_service();
        for (int u = 0; u < 2; u++) begin
            if (re[u]) begin
                check($sformatf("pop_while_nonempty_dut%0d", u), 32'(rd_ptr[u] < words.size()), 1);
                if (rd_ptr[u] < words.size()) begin
                    fifo_data[u] = words[rd_ptr[u]];
                    rd_ptr[u]++;
                end
                pops[u]++;
            end
        end
        update_flags();
    endtask

    task automatic step();
        logic [3:0] act, exp;
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            act = {re[u], ser[u], busy[u], done[u]};
            exp = m_act[u] ? model_tuple(u, m_word[u], m_idx[u]) : 4'b0100;
            if (cyc < TR) trace[u][cyc] = act;
            check($sformatf("cycle%0d_dut%0d_re_ser_busy_done", cyc, u), 32'(act), 32'(exp));
        end
        fifo_service();
    endtask

    task automatic wait_idle(input int budget);
        int n       = 0;
        bit settled = 1'b0;
        while (!settled && n < budget) begin
            step();
            n++;
            settled = !m_act[0] && !m_act[1] &&
                      (!tx_en || (rd_ptr[0] == words.size() && rd_ptr[1] == words.size()));
        end
        check("wait_idle_within_budget", 32'(settled), 1);
    endtask

    task automatic decode(input int u, input int from, input int to);
        int         i = from;
        logic [3:0] t;
        logic [7:0] v;
        dec_q.delete();
        while (i <= to) begin
            t = tr(u, i);
            if (t[BUSY_B] && !t[SER_B]) begin
                for (int k = 0; k < 8; k++) begin
                    t    = tr(u, i + CPB * (k + 1) + CPB / 2);
                    v[k] = t[SER_B];
                end
                dec_q.push_back(v);
                i += CPB * nbits(u);
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        int         t0, e0, a, s1, s2, pa, pb;
        logic [9:0] line;
        logic [3:0] t;
        logic [7:0] w;

        #1 rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++)
            check($sformatf("reset_values_dut%0d", u), 32'({re[u], ser[u], busy[u], done[u]}), 32'h4);
        repeat (2) step();
        rst   = 1'b0;
        tx_en = 1'b1;
        repeat (3) step();

        // Single 0xA5 frame on the 8N1 instance.
        t0 = cyc;
        push(8'hA5);
        repeat (52) step();
        a  = first_idx(0, t0, cyc, RE_B, 1'b1);
        s1 = first_idx(0, t0, cyc, SER_B, 1'b0);
        check("t1_pop_on_cycle_after_edge", a, t0 + 1);
        check("t1_pop_count", count_bit(0, t0, cyc, RE_B), 1);
        check("t1_start_two_after_pop", s1 - a, 2);
        for (int b = 0; b < 10; b++) begin
            t       = tr(0, s1 + CPB * b + 2);
            line[b] = t[SER_B];
        end
        check("t1_line_bits", 32'(line), 32'h34A);
        check("t1_done_offset", first_idx(0, t0, cyc, DONE_B, 1'b1) - s1, 39);
        check("t1_done_count", count_bit(0, t0, cyc, DONE_B), 1);
        check("t1_busy_cycles", count_bit(0, t0, cyc, BUSY_B), 42);
        wait_idle(200);

        // Back-to-back 0xA5, 0x07: parity and stop fields on the 8E2 instance.
        t0 = cyc;
        push(8'hA5);
        push(8'h07);
        wait_idle(400);
        s1 = first_idx(1, t0, cyc, SER_B, 1'b0);
        t  = tr(1, s1 + CPB * 9 + 2);
        check("t2_parity_a5", 32'(t[SER_B]), 0);
        check("t2_stop1_high", count_bit(1, s1 + 40, s1 + 47, SER_B), 8);
        s2 = first_idx(1, s1 + 40, cyc, SER_B, 1'b0);
        check("t2_gap_after_stop_dut1", s2 - (s1 + 48), 2);
        t  = tr(1, s2 + CPB * 9 + 2);
        check("t2_parity_07", 32'(t[SER_B]), 1);
        check("t2_stop2_high", count_bit(1, s2 + 40, s2 + 47, SER_B), 8);
        check("t2_done_count_dut1", count_bit(1, t0, cyc, DONE_B), 2);
        s1 = first_idx(0, t0, cyc, SER_B, 1'b0);
        s2 = first_idx(0, s1 + 36, cyc, SER_B, 1'b0);
        check("t2_gap_after_stop_dut0", s2 - (s1 + 40), 2);

        // Empty FIFO with Tx_Enable high: nothing may move.
        t0 = cyc;
        repeat (100) step();
        for (int u = 0; u < 2; u++) begin
            check($sformatf("t3_no_pop_dut%0d", u), count_bit(u, t0 + 1, cyc, RE_B), 0);
            check($sformatf("t3_not_busy_dut%0d", u), count_bit(u, t0 + 1, cyc, BUSY_B), 0);
            check($sformatf("t3_line_high_dut%0d", u), count_bit(u, t0 + 1, cyc, SER_B), 100);
        end

        // Tx_Enable dropped during data bit 3 with two words queued.
        t0 = cyc;
        push(8'h3C);
        push(8'hC3);
        repeat (20) step();
        tx_en = 1'b0;
        repeat (100) step();
        for (int u = 0; u < 2; u++) begin
            check($sformatf("t4_one_done_dut%0d", u), count_bit(u, t0, cyc, DONE_B), 1);
            check($sformatf("t4_one_pop_dut%0d", u), count_bit(u, t0, cyc, RE_B), 1);
        end
        decode(0, t0, cyc);
        check("t4_frames_decoded", dec_q.size(), 1);
        if (dec_q.size() > 0) check("t4_word_intact", 32'(dec_q[0]), 32'h3C);
        a     = cyc;
        tx_en = 1'b1;
        wait_idle(200);
        for (int u = 0; u < 2; u++)
            check($sformatf("t4_resume_pop_dut%0d", u), count_bit(u, a, cyc, RE_B), 1);

        // Asynchronous reset in the middle of the data field.
        t0 = cyc;
        push(8'h5A);
        repeat (12) step();
        #1 rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++)
            check($sformatf("t5_async_reset_dut%0d", u), 32'({re[u], ser[u], busy[u], done[u]}), 32'h4);
        repeat (3) step();
        rst = 1'b0;
        e0  = cyc;
        push(8'h81);
        repeat (60) step();
        check("t5_restart_pop", first_idx(0, e0, cyc, RE_B, 1'b1), e0 + 1);
        check("t5_restart_start", first_idx(0, e0, cyc, SER_B, 1'b0), e0 + 3);
        wait_idle(200);

        // Sixteen random words with random arrival gaps.
        t0 = cyc;
        pa = pops[0];
        pb = pops[1];
        sent.delete();
        for (int i = 0; i < 16; i++) begin
            w = 8'($urandom_range(0, 255));
            sent.push_back(w);
            push(w);
            repeat ($urandom_range(0, 70)) step();
        end
        wait_idle(3000);
        check("t6_pops_dut0", pops[0] - pa, 16);
        check("t6_pops_dut1", pops[1] - pb, 16);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("t6_done_count_dut%0d", u), count_bit(u, t0, cyc, DONE_B), 16);
            decode(u, t0, cyc);
            check($sformatf("t6_frames_decoded_dut%0d", u), dec_q.size(), 16);
            for (int i = 0; i < dec_q.size() && i < 16; i++)
                check($sformatf("t6_word%0d_dut%0d", i, u), 32'(dec_q[i]), 32'(sent[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
